// File: rtl/user_sobel_engine.sv
// user_sobel_engine: Sobel edge-magnitude engine with an OBI register slave.
//   Sweeps a 3x3 window over a W x H byte image held in a ROM and accumulates
//   the sum, maximum and above-threshold count of |gx|+|gy|.
//   Window fetch: 9 reads at the start of each row, 3 reads per column step.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   obi_req_i/obi_rsp_o OBI slave (gnt = req, rvalid one cycle after grant)
//   rom_req_o/rom_addr_o single outstanding ROM byte read, held until rom_valid_i
//   rom_data_i/rom_valid_i ROM read data and its valid strobe
//   irq_o               level completion interrupt
// Optional feature: define USER_SOBEL_IRQ_EN to enable CTRL b2 (irq_en) and irq_o.
//   Without it, irq_o stays 0 and CTRL b2 is ignored.

package user_sobel_obi_pkg;
  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  rid;
  } obi_rsp_t;
endpackage

module user_sobel_engine #(
  parameter user_sobel_obi_pkg::obi_cfg_t ObiCfg = user_sobel_obi_pkg::ObiDefaultConfig,
  parameter type obi_req_t = user_sobel_obi_pkg::obi_req_t,
  parameter type obi_rsp_t = user_sobel_obi_pkg::obi_rsp_t,
  parameter int unsigned PixelWidth = 8,
  parameter int unsigned MaxDim = 256,
  parameter int unsigned RomAddrW = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  obi_req_t              obi_req_i,
  output obi_rsp_t              obi_rsp_o,
  output logic                  rom_req_o,
  output logic [RomAddrW-1:0]   rom_addr_o,
  input  logic [PixelWidth-1:0] rom_data_i,
  input  logic                  rom_valid_i,
  output logic                  irq_o
);
  localparam int unsigned MagW = PixelWidth + 4;
  localparam int unsigned GW   = PixelWidth + 3;

  typedef enum logic [1:0] {IDLE, FETCH, COMPUTE, DONE} state_e;

  state_e                state_q, state_d;
  logic [31:0]           dim_q, dim_d, base_q, base_d;
  logic [MagW-1:0]       thresh_q, thresh_d, max_q, max_d;
  logic [31:0]           sum_q, sum_d, count_q, count_d;
  logic                  done_q, done_d, err_q, err_d;
  logic                  irq_en_q, irq_en_d, irq_q, irq_d;
  logic [15:0]           x_q, x_d, y_q, y_d;
  logic [3:0]            idx_q, idx_d;
  logic                  pend_q, pend_d;
  logic [RomAddrW-1:0]   rom_addr_q, rom_addr_d;
  logic [PixelWidth-1:0] win_q [9];
  logic [PixelWidth-1:0] win_d [9];
  logic                  rvalid_q, rvalid_d, rerr_q, rerr_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [3:0]            rid_q, rid_d;

  logic [15:0]     width, height;
  logic            busy, row_start, dims_bad, ctrl_err;
  logic [3:0]      fidx, last_idx, win_dest;
  logic [1:0]      row_off, col_off;
  logic [31:0]     row_idx, pix_addr;
  logic [GW-1:0]   gx_pos, gx_neg, gy_pos, gy_neg, gx, gy, abs_gx, abs_gy;
  logic [MagW-1:0] mag;
  logic [2:0]      reg_sel;
  logic [31:0]     wdata;
  logic            unused_obi;

  assign width     = dim_q[15:0];
  assign height    = dim_q[31:16];
  assign busy      = (state_q == FETCH) || (state_q == COMPUTE);
  assign row_start = (x_q == 16'd0);
  assign last_idx  = row_start ? 4'd8 : 4'd2;
  assign reg_sel   = obi_req_i.addr[4:2];
  assign wdata     = obi_req_i.wdata;
  assign dims_bad  = (width < 16'd3) || (height < 16'd3) ||
                     (32'(width) > MaxDim) || (32'(height) > MaxDim);
  // A start that arrives while busy is rejected unless abort is also set.
  assign ctrl_err  = wdata[0] & ~wdata[1] & busy;
  assign unused_obi = ^{obi_req_i.be, obi_req_i.addr[31:5], obi_req_i.addr[1:0]};

  // Address of the read about to be issued: the current index when idle on the
  // bus, or the following index when a response is accepted this cycle so the
  // next request goes out back-to-back.
  always_comb begin
    fidx = pend_q ? idx_q + 4'd1 : idx_q;
    if (row_start) begin
      if (fidx < 4'd3) begin
        row_off = 2'd0;
        col_off = fidx[1:0];
      end else if (fidx < 4'd6) begin
        row_off = 2'd1;
        col_off = 2'(fidx - 4'd3);
      end else begin
        row_off = 2'd2;
        col_off = 2'(fidx - 4'd6);
      end
    end else begin
      row_off = fidx[1:0];
      col_off = 2'd2;
    end
    row_idx  = 32'(y_q) + 32'(row_off);
    pix_addr = base_q + row_idx * 32'(width) + 32'(x_q) + 32'(col_off);
    // Row start fills the whole window; a column step fills only the right column.
    win_dest = row_start ? idx_q : 4'(idx_q * 4'd3 + 4'd2);
  end

  // Sobel kernels on the window (p0..p8 row-major); differences are two's complement.
  always_comb begin
    gx_pos = GW'(win_q[2]) + (GW'(win_q[5]) << 1) + GW'(win_q[8]);
    gx_neg = GW'(win_q[0]) + (GW'(win_q[3]) << 1) + GW'(win_q[6]);
    gy_pos = GW'(win_q[6]) + (GW'(win_q[7]) << 1) + GW'(win_q[8]);
    gy_neg = GW'(win_q[0]) + (GW'(win_q[1]) << 1) + GW'(win_q[2]);
    gx     = gx_pos - gx_neg;
    gy     = gy_pos - gy_neg;
    abs_gx = gx[GW-1] ? (~gx + GW'(1)) : gx;
    abs_gy = gy[GW-1] ? (~gy + GW'(1)) : gy;
    mag    = MagW'(abs_gx) + MagW'(abs_gy);
  end

  // Next-state: FSM progress first, then bus commands, so abort and start
  // override whatever the sweep would have done this cycle.
  always_comb begin
    state_d    = state_q;
    dim_d      = dim_q;
    base_d     = base_q;
    thresh_d   = thresh_q;
    sum_d      = sum_q;
    max_d      = max_q;
    count_d    = count_q;
    done_d     = done_q;
    err_d      = err_q;
    irq_en_d   = irq_en_q;
    x_d        = x_q;
    y_d        = y_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    rom_addr_d = rom_addr_q;
    win_d      = win_q;
    rvalid_d   = 1'b0;
    rdata_d    = '0;
    rerr_d     = 1'b0;
    rid_d      = rid_q;

    case (state_q)
      FETCH: begin
        if (!pend_q) begin
          pend_d     = 1'b1;
          rom_addr_d = RomAddrW'(pix_addr);
        end else if (rom_valid_i) begin
          win_d[win_dest] = rom_data_i;
          if (idx_q == last_idx) begin
            pend_d  = 1'b0;
            idx_d   = 4'd0;
            state_d = COMPUTE;
          end else begin
            idx_d      = idx_q + 4'd1;
            rom_addr_d = RomAddrW'(pix_addr);
          end
        end
      end
      COMPUTE: begin
        sum_d = sum_q + 32'(mag);
        if (mag > max_q) max_d = mag;
        if (mag > thresh_q) count_d = count_q + 32'd1;
        // Shift left; harmless on a row change because the next fetch refills all nine.
        win_d[0] = win_q[1]; win_d[1] = win_q[2];
        win_d[3] = win_q[4]; win_d[4] = win_q[5];
        win_d[6] = win_q[7]; win_d[7] = win_q[8];
        state_d  = FETCH;
        if (x_q + 16'd1 == width - 16'd2) begin
          x_d = 16'd0;
          y_d = y_q + 16'd1;
          if (y_q + 16'd1 == height - 16'd2) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          x_d = x_q + 16'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: ;
    endcase

    if (obi_req_i.req) begin
      rvalid_d = 1'b1;
      rid_d    = obi_req_i.aid;
      if (obi_req_i.we) begin
        case (reg_sel)
          3'd0: begin
            if (ctrl_err) begin
              rerr_d = 1'b1;
            end else begin
`ifdef USER_SOBEL_IRQ_EN
              irq_en_d = wdata[2];
`endif
              if (wdata[1]) begin
                if (busy) begin
                  state_d = IDLE;
                  pend_d  = 1'b0;
                  idx_d   = 4'd0;
                  done_d  = 1'b0;
                end
              end else if (wdata[0]) begin
                sum_d   = '0;
                max_d   = '0;
                count_d = '0;
                done_d  = 1'b0;
                err_d   = 1'b0;
                x_d     = 16'd0;
                y_d     = 16'd0;
                idx_d   = 4'd0;
                pend_d  = 1'b0;
                if (dims_bad) begin
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = DONE;
                end else begin
                  state_d = FETCH;
                end
              end
            end
          end
          3'd1: begin
            done_d = 1'b0;
            err_d  = 1'b0;
          end
          3'd2: if (busy) rerr_d = 1'b1; else dim_d = wdata;
          3'd3: if (busy) rerr_d = 1'b1; else base_d = wdata;
          3'd4: if (busy) rerr_d = 1'b1; else thresh_d = wdata[MagW-1:0];
          default: rerr_d = 1'b1;
        endcase
      end else begin
        case (reg_sel)
          3'd0:    rdata_d = {29'd0, irq_en_q, 2'd0};
          3'd1:    rdata_d = {29'd0, err_q, done_q, busy};
          3'd2:    rdata_d = dim_q;
          3'd3:    rdata_d = base_q;
          3'd4:    rdata_d = 32'(thresh_q);
          3'd5:    rdata_d = sum_q;
          3'd6:    rdata_d = 32'(max_q);
          default: rdata_d = count_q;
        endcase
      end
    end

    // irq_en only ever becomes 1 when the interrupt feature is compiled in.
    irq_d = done_d & irq_en_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      dim_q      <= '0;
      base_q     <= '0;
      thresh_q   <= '0;
      sum_q      <= '0;
      max_q      <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      rom_addr_q <= '0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rerr_q     <= 1'b0;
      rid_q      <= '0;
    end else begin
      state_q    <= state_d;
      dim_q      <= dim_d;
      base_q     <= base_d;
      thresh_q   <= thresh_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      count_q    <= count_d;
      done_q     <= done_d;
      err_q      <= err_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      x_q        <= x_d;
      y_q        <= y_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      rom_addr_q <= rom_addr_d;
      win_q      <= win_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rerr_q     <= rerr_d;
      rid_q      <= rid_d;
    end
  end

  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = obi_req_i.req;
    obi_rsp_o.rvalid = rvalid_q;
    obi_rsp_o.rdata  = rdata_q;
    obi_rsp_o.err    = rerr_q;
    obi_rsp_o.rid    = rid_q;
  end

  assign rom_req_o  = pend_q;
  assign rom_addr_o = rom_addr_q;
  assign irq_o      = irq_q;
endmodule

// File: tb/tb_user_sobel_engine.sv
// Self-checking bench for user_sobel_engine: random-latency ROM responder,
// OBI register access tasks, and a loop-based Sobel reference model.
module tb_user_sobel_engine;
   import user_sobel_obi_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   obi_req_t    obiReq;
   obi_rsp_t    obiRsp;
   logic        romReq;
   logic [31:0] romAddr;
   logic [7:0]  romData;
   logic        romValid;
   logic        irq;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem [0:4095];
   int          maxDelay = 0;
   bit          romHold = 1'b0;
   bit          romBusy = 1'b0;
   bit          romReqSeen = 1'b0;
   int          romCount = 0;
   int          romReads = 0;
   logic [31:0] romLatAddr = '0;

   logic        sampledReq;
   logic [3:0]  sampledAid;

   user_sobel_engine dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .obi_req_i   (obiReq),
      .obi_rsp_o   (obiRsp),
      .rom_req_o   (romReq),
      .rom_addr_o  (romAddr),
      .rom_data_i  (romData),
      .rom_valid_i (romValid),
      .irq_o       (irq)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // One OBI transaction; returns read data and the error flag of the response.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err);
      @(negedge clk_i);
      obiReq.req   = 1'b1;
      obiReq.we    = we;
      obiReq.be    = 4'hF;
      obiReq.addr  = addr;
      obiReq.wdata = wdata;
      obiReq.aid   = 4'($urandom);
      @(negedge clk_i);
      rdata = obiRsp.rdata;
      err   = obiRsp.err;
      obiReq.req = 1'b0;
      obiReq.we  = 1'b0;
   endtask

   task automatic busWrite(input logic [31:0] addr, input logic [31:0] data, input logic expErr, input string name);
      logic [31:0] d;
      logic        e;
      applyStimulus(1'b1, addr, data, d, e);
      checkOutput(name, 64'(e), 64'(expErr));
   endtask

   task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
      logic e;
      applyStimulus(1'b0, addr, 32'd0, data, e);
      checkOutput("readErr", 64'(e), 64'd0);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   // Poll STATUS until done; an exhausted budget counts as a failure.
   task automatic waitDone(input string tag);
      logic [31:0] st;
      bit          seen = 1'b0;
      for (int i = 0; i < 5000 && !seen; i++) begin
         busRead(32'h04, st);
         if (st[1]) seen = 1'b1;
      end
      checkOutput({tag, "_doneSeen"}, 64'(seen), 64'd1);
      if (seen) checkOutput({tag, "_statusDone"}, 64'(st), 64'd2);
   endtask

   // Plain nested-loop Sobel over the image in the bench memory.
   function automatic void sobelModel(input int base, input int w, input int h, input int thresh,
                                      output longint sum, output int mx, output int cnt);
      int p [3][3];
      int gx, gy, mag;
      sum = 0; mx = 0; cnt = 0;
      for (int y = 0; y <= h - 3; y++) begin
         for (int x = 0; x <= w - 3; x++) begin
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++)
                  p[r][c] = int'(mem[(base + (y + r) * w + x + c) & 4095]);
            gx  = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
            gy  = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
            mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            sum += mag;
            if (mag > mx) mx = mag;
            if (mag > thresh) cnt++;
         end
      end
   endfunction

   task automatic runImage(input int base, input int w, input int h, input int thresh, input string tag,
                           output logic [31:0] sum, output logic [31:0] mx, output logic [31:0] cnt);
      longint eSum;
      int     eMax, eCnt;
      logic [15:0] w16, h16;
      w16 = 16'(w);
      h16 = 16'(h);
      busWrite(32'h08, {h16, w16}, 1'b0, "dimWrite");
      busWrite(32'h0C, 32'(base), 1'b0, "baseWrite");
      busWrite(32'h10, 32'(thresh), 1'b0, "threshWrite");
      romReads = 0;
      busWrite(32'h00, 32'h5, 1'b0, "start");
      waitDone(tag);
      busRead(32'h14, sum);
      busRead(32'h18, mx);
      busRead(32'h1C, cnt);
      sobelModel(base, w, h, thresh, eSum, eMax, eCnt);
      checkOutput({tag, "_sum"}, 64'(sum), 64'(eSum));
      checkOutput({tag, "_max"}, 64'(mx), 64'(eMax));
      checkOutput({tag, "_count"}, 64'(cnt), 64'(eCnt));
      checkOutput({tag, "_reads"}, 64'(romReads), 64'((h - 2) * (9 + 3 * (w - 3))));
   endtask

   // ROM responder: random latency, one-cycle valid pulse, address must hold while pending.
   always @(negedge clk_i) begin
      romValid = 1'b0;
      if (rst_i) begin
         romBusy = 1'b0;
      end else begin
         if (romReq) romReqSeen = 1'b1;
         if (romBusy && romReq) checkOutput("romAddrStable", 64'(romAddr), 64'(romLatAddr));
         if (!romBusy && romReq) begin
            romBusy    = 1'b1;
            romLatAddr = romAddr;
            romCount   = $urandom_range(0, maxDelay);
         end
         if (romBusy && !romHold) begin
            if (romCount == 0) begin
               romValid = 1'b1;
               romData  = mem[romLatAddr[11:0]];
               romBusy  = 1'b0;
               romReads++;
            end else begin
               romCount--;
            end
         end
      end
   end

   // Per-cycle bus protocol checks: same-cycle grant, rvalid/rid one cycle later.
   always @(posedge clk_i) begin
      sampledReq = obiReq.req;
      sampledAid = obiReq.aid;
      #2;
      if (!rst_i) begin
         checkOutput("gnt", 64'(obiRsp.gnt), 64'(sampledReq));
         checkOutput("rvalid", 64'(obiRsp.rvalid), 64'(sampledReq));
         if (sampledReq) checkOutput("rid", 64'(obiRsp.rid), 64'(sampledAid));
`ifndef USER_SOBEL_IRQ_EN
         checkOutput("irqTied", 64'(irq), 64'd0);
`endif
      end
   end

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] d, s, m, c;
      logic [7:0]  mid;
      bit          reached;
      int          w, h, base, th;
      longint      eSum;
      int          eMax, eCnt;

      obiReq   = '0;
      romValid = 1'b0;
      romData  = '0;
      rst_i    = 1'b1;
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      waitCycles(3);
      rst_i = 1'b0;
      waitCycles(1);

      // Reset state
      checkOutput("rstRomReq", 64'(romReq), 64'd0);
      checkOutput("rstRomAddr", 64'(romAddr), 64'd0);
      checkOutput("rstIrq", 64'(irq), 64'd0);
      busRead(32'h04, d); checkOutput("rstStatus", 64'(d), 64'd0);
      busRead(32'h08, d); checkOutput("rstDim", 64'(d), 64'd0);
      busRead(32'h14, d); checkOutput("rstSum", 64'(d), 64'd0);
      busRead(32'h1C, d); checkOutput("rstCount", 64'(d), 64'd0);

      // THRESH keeps only PixelWidth+4 bits
      busWrite(32'h10, 32'hFFFF_FFFF, 1'b0, "threshAll");
      busRead(32'h10, d); checkOutput("threshMask", 64'(d), 64'h0FFF);

      // 3x3 vertical edge: left column 0, right column 255
      mid = 8'($urandom);
      for (int r = 0; r < 3; r++) begin
         mem[256 + r * 3]     = 8'd0;
         mem[256 + r * 3 + 1] = mid;
         mem[256 + r * 3 + 2] = 8'd255;
      end
      maxDelay = 2;
      runImage(256, 3, 3, 1000, "edge3x3", s, m, c);
      checkOutput("edge3x3_sumLit", 64'(s), 64'd1020);
      checkOutput("edge3x3_maxLit", 64'(m), 64'd1020);
      checkOutput("edge3x3_countLit", 64'(c), 64'd1);
      checkOutput("edge3x3_readsLit", 64'(romReads), 64'd9);

      // Flat 4x4 image
      for (int i = 0; i < 16; i++) mem[512 + i] = 8'd100;
      runImage(512, 4, 4, 0, "flat4x4", s, m, c);
      checkOutput("flat4x4_sumLit", 64'(s), 64'd0);
      checkOutput("flat4x4_maxLit", 64'(m), 64'd0);
      checkOutput("flat4x4_readsLit", 64'(romReads), 64'd24);

      // Rejected dimensions: no ROM access, err and done right away
      romReqSeen = 1'b0;
      busWrite(32'h08, {16'd5, 16'd2}, 1'b0, "dimSmall");
      busWrite(32'h00, 32'h5, 1'b0, "startSmall");
      busRead(32'h04, d); checkOutput("smallStatus", 64'(d), 64'd6);
      busWrite(32'h08, {16'd3, 16'd257}, 1'b0, "dimWide");
      busWrite(32'h00, 32'h5, 1'b0, "startWide");
      busRead(32'h04, d); checkOutput("wideStatus", 64'(d), 64'd6);
      waitCycles(5);
      checkOutput("smallNoRomReq", 64'(romReqSeen), 64'd0);
      busWrite(32'h04, 32'h0, 1'b0, "statusClear0");
      busRead(32'h04, d); checkOutput("statusCleared0", 64'(d), 64'd0);

      // Random images with random ROM latency
      maxDelay = 5;
      runImage(1024, 8, 6, 400, "rand8x6", s, m, c);
      for (int k = 0; k < 3; k++) begin
         w    = $urandom_range(3, 10);
         h    = $urandom_range(3, 8);
         base = $urandom_range(0, 3000);
         th   = $urandom_range(0, 1200);
         runImage(base, w, h, th, "randDim", s, m, c);
      end

      // Abort with a response held back until after the abort
      maxDelay = 2;
      busWrite(32'h08, {16'd6, 16'd8}, 1'b0, "abortDim");
      busWrite(32'h0C, 32'd1536, 1'b0, "abortBase");
      romReads = 0;
      busWrite(32'h00, 32'h5, 1'b0, "abortStart");
      reached = 1'b0;
      for (int i = 0; i < 500 && !reached; i++) begin
         @(negedge clk_i);
         if (romReads >= 5) reached = 1'b1;
      end
      romHold = 1'b1;
      reached = 1'b0;
      for (int i = 0; i < 20 && !reached; i++) begin
         @(negedge clk_i);
         if (romBusy && romReq) reached = 1'b1;
      end
      checkOutput("abortPending", 64'(reached), 64'd1);
      waitCycles(2);
      busWrite(32'h00, 32'h2, 1'b0, "abort");
      checkOutput("abortRomReqDrop", 64'(romReq), 64'd0);
      busRead(32'h04, d); checkOutput("abortStatus", 64'(d), 64'd0);
      romHold = 1'b0;
      waitCycles(4);
      busRead(32'h04, d); checkOutput("abortStaleIgnored", 64'(d), 64'd0);
      runImage(1536, 8, 6, 500, "afterAbort", s, m, c);

      // Illegal accesses while busy
      maxDelay = 3;
      busWrite(32'h08, {16'd5, 16'd7}, 1'b0, "busyDim");
      busWrite(32'h0C, 32'd2048, 1'b0, "busyBase");
      busWrite(32'h10, 32'd300, 1'b0, "busyThresh");
      busWrite(32'h00, 32'h5, 1'b0, "busyStart");
      busWrite(32'h0C, 32'h123, 1'b1, "baseWhileBusy");
      busRead(32'h0C, d); checkOutput("baseUnchanged", 64'(d), 64'd2048);
      busWrite(32'h08, {16'd3, 16'd3}, 1'b1, "dimWhileBusy");
      busWrite(32'h14, 32'd0, 1'b1, "sumReadOnly");
      busWrite(32'h00, 32'h1, 1'b1, "startWhileBusy");
      busRead(32'h04, d); checkOutput("busyBit", 64'(d[0]), 64'd1);
      waitDone("busyRun");
      sobelModel(2048, 7, 5, 300, eSum, eMax, eCnt);
      busRead(32'h14, d); checkOutput("busyRun_sum", 64'(d), 64'(eSum));
      busRead(32'h1C, d); checkOutput("busyRun_count", 64'(d), 64'(eCnt));
      busRead(32'h00, d);
`ifdef USER_SOBEL_IRQ_EN
      checkOutput("ctrlIrqEn", 64'(d), 64'd4);
      waitCycles(2);
      checkOutput("irqRaised", 64'(irq), 64'd1);
      busWrite(32'h04, 32'h0, 1'b0, "statusClearIrq");
      waitCycles(2);
      checkOutput("irqCleared", 64'(irq), 64'd0);
`else
      checkOutput("ctrlReadsZero", 64'(d), 64'd0);
      busWrite(32'h04, 32'h0, 1'b0, "statusClearIrq");
`endif
      busRead(32'h04, d); checkOutput("finalStatus", 64'(d), 64'd0);

      waitCycles(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
